// File: rtl/register_bank.sv
// Eight 8-bit CPU registers, also readable/writable as four 16-bit pairs.
// Define REGBANK_REGISTERED_OUTPUT_EN to register dataOut/dataOut16 (one-cycle read latency).
module register_bank (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  regNum,
    input  logic [7:0]  dataIn,
    output logic [7:0]  dataOut,
    input  logic        writeEnable,
    input  logic [15:0] dataIn16,
    output logic [15:0] dataOut16,
    input  logic        writeEnable16
);

    logic [7:0] registers [0:7];
    logic [7:0] next_regs [0:7];
    logic [1:0] pair;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;

    assign pair   = regNum[2:1];
    assign hi_idx = {pair, 1'b0};
    assign lo_idx = {pair, 1'b1};

    // Post-write contents; reset only gates the enables, it never clears storage.
    always_comb begin
        next_regs = registers;
        if (!reset) begin
            if (writeEnable16) begin
                next_regs[hi_idx] = dataIn16[15:8];
                next_regs[lo_idx] = dataIn16[7:0];
            end else if (writeEnable) begin
                next_regs[regNum] = dataIn;
            end
        end
    end

    always_ff @(posedge clk) begin
        registers <= next_regs;
    end

`ifdef REGBANK_REGISTERED_OUTPUT_EN
    always_ff @(posedge clk) begin
        dataOut   <= next_regs[regNum];
        dataOut16 <= {next_regs[hi_idx], next_regs[lo_idx]};
    end
`else
    assign dataOut   = registers[regNum];
    assign dataOut16 = {registers[hi_idx], registers[lo_idx]};
`endif

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: expected reads queued at drive time, popped after the edge.
module tb_register_bank;

    logic        clk;
    logic        reset;
    logic [2:0]  regNum;
    logic [7:0]  dataIn;
    logic [7:0]  dataOut;
    logic        writeEnable;
    logic [15:0] dataIn16;
    logic [15:0] dataOut16;
    logic        writeEnable16;

    register_bank dut (
        .clk(clk),
        .reset(reset),
        .regNum(regNum),
        .dataIn(dataIn),
        .dataOut(dataOut),
        .writeEnable(writeEnable),
        .dataIn16(dataIn16),
        .dataOut16(dataOut16),
        .writeEnable16(writeEnable16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0]  mdl [0:7];
    logic [7:0]  exp8_q [$];
    logic [15:0] exp16_q [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then compare outputs after the edge.
    task automatic step(input logic rst, input logic [2:0] idx, input logic [7:0] d8,
                        input logic we, input logic [15:0] d16, input logic we16);
        logic [7:0]  e8;
        logic [15:0] e16;
        reset = rst; regNum = idx; dataIn = d8; writeEnable = we;
        dataIn16 = d16; writeEnable16 = we16;
        if (!rst) begin
            if (we16) begin
                mdl[{idx[2:1], 1'b0}] = d16[15:8];
                mdl[{idx[2:1], 1'b1}] = d16[7:0];
            end else if (we) begin
                mdl[idx] = d8;
            end
        end
        exp8_q.push_back(mdl[idx]);
        exp16_q.push_back({mdl[{idx[2:1], 1'b0}], mdl[{idx[2:1], 1'b1}]});
        @(posedge clk);
        #1;
        writeEnable = 1'b0; writeEnable16 = 1'b0;
        if (exp8_q.size() == 0 || exp16_q.size() == 0) begin
            check("queue_empty", 16'(exp8_q.size()), 16'd1);
        end else begin
            e8 = exp8_q.pop_front();
            e16 = exp16_q.pop_front();
            check("dataOut", {8'h00, dataOut}, {8'h00, e8});
            check("dataOut16", dataOut16, e16);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 8; k++)
            check(tag, {8'h00, dut.registers[k]}, {8'h00, mdl[k]});
    endtask

    task automatic zero_all();
        for (int k = 0; k < 8; k += 2)
            step(1'b0, 3'(k), 8'h00, 1'b0, 16'h0000, 1'b1);
    endtask

    logic [7:0]  preload [0:7];
    logic [15:0] pair_tbl [0:7];

    initial begin
        preload  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hBA, 8'hBA, 8'hBA, 8'hBE};
        pair_tbl = '{16'hDEAD, 16'hDEAD, 16'hBEEF, 16'hBEEF, 16'hBABA, 16'hBABA, 16'hBABE, 16'hBABE};
        reset = 1'b1; regNum = 3'd0; dataIn = 8'h00; writeEnable = 1'b0;
        dataIn16 = 16'h0000; writeEnable16 = 1'b0;
        for (int k = 0; k < 8; k++) mdl[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        // Establish known contents, then confirm reset blocks writes.
        zero_all();
        check_all("zero_init");
        step(1'b1, 3'd6, 8'h99, 1'b1, 16'h5A5A, 1'b1);
        check_all("reset_hold");

        for (int i = 0; i < 8; i++) begin
            zero_all();
            step(1'b0, 3'(i), 8'hFF, 1'b1, 16'h0000, 1'b0);
            check_all("iso_write");
            step(1'b0, 3'(i), 8'hF0, 1'b0, 16'h0000, 1'b0);
            check({8'h00, dataOut}, 16'h00FF, 16'h00FF) ;
        end

        for (int i = 0; i < 8; i++)
            step(1'b0, 3'(i), preload[i], 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 8'h11, 1'b1, 16'hFFFF, 1'b1);
            check("pair_rst", dataOut16, pair_tbl[i]);
        end
        for (int k = 0; k < 8; k++)
            check("preload_kept", {8'h00, dut.registers[k]}, {8'h00, preload[k]});

        step(1'b0, 3'd5, 8'h00, 1'b0, 16'h1234, 1'b1);
        check("w16_hi", {8'h00, dut.registers[4]}, 16'h0012);
        check("w16_lo", {8'h00, dut.registers[5]}, 16'h0034);
        check_all("w16_others");
        step(1'b0, 3'd4, 8'h00, 1'b0, 16'h0000, 1'b0);
        check("w16_read", {8'h00, dataOut}, 16'h0012);

        step(1'b0, 3'd2, 8'h55, 1'b1, 16'hA1B2, 1'b1);
        check("prio_hi", {8'h00, dut.registers[2]}, 16'h00A1);
        check("prio_lo", {8'h00, dut.registers[3]}, 16'h00B2);

        step(1'b0, 3'd3, 8'hEF, 1'b1, 16'h0000, 1'b0);
        step(1'b1, 3'd3, 8'h77, 1'b1, 16'h0000, 1'b0);
        check("rst_inhibit", {8'h00, dut.registers[3]}, 16'h00EF);

        for (int n = 0; n < 200; n++)
            step(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
        check_all("random_final");
        check("queue_drained", 16'(exp8_q.size() + exp16_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
